fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register of the RISC-V core.
//   Owns the PC, drives the instruction-memory address, and applies stall_IF/stall_ID
//   from hazard_handler and branch redirects from EX.
//   Provides IF_ID_rs1/IF_ID_rs2 back to hazard_handler and the IF/ID bundle to decode.
// PARAMETERS
//   XLEN      32             datapath/PC width
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_INSTR 32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//   clk            in   1     core clock, all state on rising edge
//   rst            in   1     reset, asynchronous, active-high
//   stall_IF       in   1     hold PC (from hazard_handler)
//   stall_ID       in   1     hold IF/ID register (from hazard_handler)
//   branch_taken   in   1     redirect request from EX, flushes IF/ID
//   branch_target  in   XLEN  redirect PC
//   imem_addr      out  XLEN  fetch address (= pc, combinational)
//   imem_rdata     in   32    instruction at imem_addr, valid when imem_valid
//   imem_valid     in   1     memory returned imem_rdata this cycle
//   IF_ID_pc       out  XLEN  PC of instruction in IF/ID
//   IF_ID_instr    out  32    instruction in IF/ID (NOP_INSTR when bubble)
//   IF_ID_valid    out  1     IF/ID holds a real instruction
//   IF_ID_rs1      out  5     IF_ID_instr[19:15]
//   IF_ID_rs2      out  5     IF_ID_instr[24:20]
//   fetch_count    out  16    instructions accepted into IF/ID, wraps at 16'hFFFF->0
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, IF_ID_pc=0, IF_ID_instr=NOP_INSTR,
//     IF_ID_valid=0, fetch_count=0, FSM=BOOT. rs1/rs2 therefore read 0.
//   FSM: BOOT -> RUN after one clock (no fetch accepted in BOOT; IF/ID stays bubble).
//     RUN -> WAIT when imem_valid=0 and no stall/redirect; WAIT -> RUN when imem_valid=1.
//     Any state -> RUN on branch_taken (except BOOT, which ignores branch_taken).
//   Priority per cycle (highest first):
//     1 branch_taken: pc<=branch_target with [1:0] forced to 2'b00; IF/ID<=bubble
//       (valid=0, instr=NOP_INSTR, pc=0); overrides stall_IF/stall_ID; instruction
//       returned this cycle is discarded, fetch_count unchanged.
//     2 stall_ID=1: IF/ID holds; pc holds regardless of stall_IF (no instruction lost).
//     3 stall_IF=1, stall_ID=0: pc holds; IF/ID<=bubble.
//     4 imem_valid=0: pc holds; IF/ID<=bubble.
//     5 otherwise: IF/ID<={pc, imem_rdata, valid=1}; pc<=pc+4 (wraps mod 2^XLEN);
//       fetch_count<=fetch_count+1.
//   Latency: instruction at pc appears on IF_ID_* one clock after imem_valid=1 accept.
//   imem_addr is pc directly; stable during stall and WAIT.
//   Reset mid-operation: all state returns to reset values asynchronously; first
//     fetch is accepted no earlier than the second rising edge after rst falls.
// TESTING
//   T1 reset: rst=1 -> imem_addr=0, IF_ID_valid=0, IF_ID_instr=32'h13, rs1=rs2=0, count=0.
//   T2 stream: imem_valid=1, instrs A0..A3 -> IF_ID_pc 0,4,8,12 on consecutive cycles; count=4.
//   T3 load-use: stall_IF=stall_ID=1 for 1 cycle at pc=8 -> IF_ID holds pc=4, imem_addr stays 8,
//      then resumes with pc=8.
//   T4 branch during stall: stall_ID=1, branch_taken=1, target=32'h103 -> pc=32'h100,
//      IF_ID bubble next cycle, count unchanged.
//   T5 memory wait: imem_valid=0 for 3 cycles -> 3 bubbles, imem_addr constant, FSM in WAIT;
//      valid returns -> fetch accepted.
//   T6 reset mid-run at pc=32'h40, count=9 -> immediate pc=0, count=0, IF_ID bubble; BOOT cycle honoured.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, applies
// hazard stalls and EX redirects, and presents the fetched bundle to decode.
module fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_IF,
  input  logic            stall_ID,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr,
  output logic            IF_ID_valid,
  output logic [4:0]      IF_ID_rs1,
  output logic [4:0]      IF_ID_rs2,
  output logic [15:0]     fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [15:0]     count_q, count_d;

  // Highest-priority condition wins; BOOT neither fetches nor redirects.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    if (state_q == ST_BOOT) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (branch_taken) begin
      pc_d         = {branch_target[XLEN-1:2], 2'b00};
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (stall_ID) begin
      // IF/ID and PC both hold so the in-flight instruction is refetched later.
    end else if (stall_IF || !imem_valid) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d         = pc_q + XLEN'(4);
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      count_d      = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (!branch_taken && !imem_valid && !stall_IF && !stall_ID)
            state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (branch_taken || imem_valid) state_q <= ST_RUN;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;
  assign IF_ID_rs1   = ifid_instr_q[19:15];
  assign IF_ID_rs2   = ifid_instr_q[24:20];
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stalls, redirects,
// memory wait, PC wrap and mid-run reset with the BOOT cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IF, stall_ID, branch_taken, imem_valid;
  logic [31:0] branch_target, imem_addr, imem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_instr;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .stall_ID(stall_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory word: rs1 = addr[6:2], rs2 = ~addr[6:2], so each PC has distinct fields.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {7'b0, a[6:2] ^ 5'h1F, a[6:2], 3'b000, 5'd1, 7'h13};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetched(input string tag, input logic [31:0] pc,
                             input logic [31:0] next_addr, input logic [15:0] cnt);
    chk({tag, " valid"}, 32'(IF_ID_valid), 32'd1);
    chk({tag, " pc"},    IF_ID_pc, pc);
    chk({tag, " instr"}, IF_ID_instr, mem_word(pc));
    chk({tag, " addr"},  imem_addr, next_addr);
    chk({tag, " count"}, 32'(fetch_count), 32'(cnt));
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] addr, input logic [15:0] cnt);
    chk({tag, " valid"}, 32'(IF_ID_valid), 32'd0);
    chk({tag, " instr"}, IF_ID_instr, 32'h13);
    chk({tag, " addr"},  imem_addr, addr);
    chk({tag, " count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; stall_IF = 1'b0; stall_ID = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_valid = 1'b1;
    #3;
    // T1: asynchronous reset before any clock edge
    chk("T1 addr",  imem_addr, 32'h0);
    chk("T1 valid", 32'(IF_ID_valid), 32'd0);
    chk("T1 instr", IF_ID_instr, 32'h13);
    chk("T1 rs1",   32'(IF_ID_rs1), 32'd0);
    chk("T1 rs2",   32'(IF_ID_rs2), 32'd0);
    chk("T1 count", 32'(fetch_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_bubble("BOOT", 32'h0, 16'd0);

    // T2/T3: stream with a load-use stall at pc=8
    tick();
    chk_fetched("T2 A0", 32'h0, 32'h4, 16'd1);
    tick();
    chk_fetched("T2 A1", 32'h4, 32'h8, 16'd2);
    stall_IF = 1'b1; stall_ID = 1'b1;
    tick();
    chk_fetched("T3 hold", 32'h4, 32'h8, 16'd2);
    stall_IF = 1'b0; stall_ID = 1'b0;
    tick();
    chk_fetched("T3 A2", 32'h8, 32'hC, 16'd3);
    tick();
    chk_fetched("T2 A3", 32'hC, 32'h10, 16'd4);
    chk("T2 rs1", 32'(IF_ID_rs1), 32'd3);
    chk("T2 rs2", 32'(IF_ID_rs2), 32'd28);

    // T4: redirect overrides stall_ID
    stall_ID = 1'b1; branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    chk_bubble("T4 br", 32'h100, 16'd4);
    chk("T4 ifid pc", IF_ID_pc, 32'h0);
    stall_ID = 1'b0; branch_taken = 1'b0;
    tick();
    chk_fetched("T4 tgt", 32'h100, 32'h104, 16'd5);

    // T5: memory wait for three cycles
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bubble($sformatf("T5 wait%0d", i), 32'h104, 16'd5);
    end
    imem_valid = 1'b1;
    tick();
    chk_fetched("T5 resume", 32'h104, 32'h108, 16'd6);

    // stall_IF alone inserts a bubble and holds pc
    stall_IF = 1'b1;
    tick();
    chk_bubble("SIF", 32'h108, 16'd6);
    stall_IF = 1'b0;

    // Redirect forces [1:0]=0, then pc wraps past 2^32
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    chk_bubble("WRAP br", 32'hFFFF_FFFC, 16'd6);
    branch_taken = 1'b0;
    tick();
    chk_fetched("WRAP", 32'hFFFF_FFFC, 32'h0, 16'd7);

    // T6: reach pc=0x40 with count=9, then reset mid-run
    branch_taken = 1'b1; branch_target = 32'h38;
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    chk_fetched("T6 pre", 32'h3C, 32'h40, 16'd9);
    #2 rst = 1'b1;
    #1;
    chk_bubble("T6 rst", 32'h0, 16'd0);
    chk("T6 ifid pc", IF_ID_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    chk_bubble("T6 BOOT", 32'h0, 16'd0);
    branch_taken = 1'b0;
    tick();
    chk_fetched("T6 first", 32'h0, 32'h4, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
